// File: rtl/div_arbiter_pkg.sv
// Shared definitions for the divider arbiter: FSM encoding, step counter sizing
// and the divide-by-zero quotient.
package div_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int              CNT_W    = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = 5'd31;
    localparam logic [31:0]     DIV0_QUO = 32'hFFFF_FFFF;

    // Magnitude of a 32-bit operand; only negated when the lane asked for signed.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_arbiter_if.sv
// Lane-side bundle of the shared divider: requests and operands in, grant,
// completion and result out.
interface div_arbiter_if #(
    parameter int NUM_REQ = 4
);
    // req is a level held by a lane until its done pulse; grant is one-hot and
    // stays high from the grant edge through the done cycle; done pulses for one
    // cycle with result valid in that cycle only. Dropping req while granted aborts.
    logic [NUM_REQ-1:0]    req;
    logic [32*NUM_REQ-1:0] dividend;
    logic [32*NUM_REQ-1:0] divisor;
    logic [NUM_REQ-1:0]    is_signed;
    logic [NUM_REQ-1:0]    want_rem;
    logic [NUM_REQ-1:0]    grant;
    logic [NUM_REQ-1:0]    done;
    logic [31:0]           result;
    logic                  busy;

    modport master (
        output req, dividend, divisor, is_signed, want_rem,
        input  grant, done, result, busy
    );

    modport slave (
        input  req, dividend, divisor, is_signed, want_rem,
        output grant, done, result, busy
    );
endinterface

// File: rtl/div_core.sv
// Unsigned restoring divider: loads magnitudes on start, then retires one
// quotient bit per step; last flags the 32nd step.
module div_core
    import div_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        step,
    input  logic [31:0] a_mag,
    input  logic [31:0] b_mag,
    output logic [31:0] quo,
    output logic [31:0] rem,
    output logic        last
);
    logic [31:0]      quo_q, quo_d;
    logic [31:0]      rem_q, rem_d;
    logic [31:0]      b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      shl;
    logic [32:0]      trial;

    always_comb begin
        quo_d = quo_q;
        rem_d = rem_q;
        b_d   = b_q;
        cnt_d = cnt_q;
        shl   = {rem_q[30:0], quo_q[31]};
        trial = {rem_q, quo_q[31]} - {1'b0, b_q};
        if (start) begin
            quo_d = a_mag;
            rem_d = '0;
            b_d   = b_mag;
            cnt_d = '0;
        end else if (step) begin
            // A clear borrow means the divisor fits; a zero divisor always fits,
            // which yields an all-ones quotient and the dividend as remainder.
            rem_d = trial[32] ? shl : trial[31:0];
            quo_d = {quo_q[30:0], ~trial[32]};
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q <= '0;
            rem_q <= '0;
            b_q   <= '0;
            cnt_q <= '0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
        end
    end

    assign quo  = quo_q;
    assign rem  = rem_q;
    assign last = step && (cnt_q == CNT_LAST);
endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one restoring divider among NUM_REQ lanes;
// owns lane selection, sign handling and the IDLE/RUN/DONE sequencing.
module div_arbiter
    import div_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic         wb_clk_i,
    input  logic         rst,
    div_arbiter_if.slave bus,
    output state_e       dbg_state
);
    localparam int LANE_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e             state_q, state_d;
    logic [LANE_W-1:0]  ptr_q, ptr_d;
    logic [LANE_W-1:0]  owner_q, owner_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic               want_rem_q, want_rem_d;
    logic               div0_q, div0_d;

    logic [LANE_W-1:0]  cand, pick;
    logic               pick_found;
    logic [31:0]        sel_a, sel_b, a_mag, b_mag;
    logic               sel_signed;
    logic               core_start, core_step, core_last;
    logic [31:0]        core_quo, core_rem, quo_fix, rem_fix;

    // First requesting lane at or after ptr, wrapping around.
    always_comb begin
        cand       = '0;
        pick       = '0;
        pick_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = LANE_W'((int'(ptr_q) + i) % NUM_REQ);
            if (!pick_found && bus.req[cand]) begin
                pick_found = 1'b1;
                pick       = cand;
            end
        end
    end

    assign sel_a      = bus.dividend[32*int'(pick) +: 32];
    assign sel_b      = bus.divisor[32*int'(pick) +: 32];
    assign sel_signed = bus.is_signed[pick];
    assign a_mag      = abs32(sel_a, sel_signed);
    assign b_mag      = abs32(sel_b, sel_signed);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        grant_d    = grant_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        want_rem_d = want_rem_q;
        div0_d     = div0_q;
        core_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d       = ST_RUN;
                    core_start    = 1'b1;
                    owner_d       = pick;
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    ptr_d         = (int'(pick) == NUM_REQ - 1) ? '0 : pick + 1'b1;
                    neg_quo_d     = sel_signed & (sel_a[31] ^ sel_b[31]);
                    neg_rem_d     = sel_signed & sel_a[31];
                    want_rem_d    = bus.want_rem[pick];
                    div0_d        = (sel_b == '0);
                end
            end
            ST_RUN: begin
                if (!bus.req[owner_q]) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end else if (core_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            grant_q    <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            want_rem_q <= 1'b0;
            div0_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            grant_q    <= grant_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            want_rem_q <= want_rem_d;
            div0_q     <= div0_d;
        end
    end

    assign core_step = (state_q == ST_RUN);

    div_core u_core (
        .clk   (wb_clk_i),
        .rst   (rst),
        .start (core_start),
        .step  (core_step),
        .a_mag (a_mag),
        .b_mag (b_mag),
        .quo   (core_quo),
        .rem   (core_rem),
        .last  (core_last)
    );

    // Remainder follows the dividend sign, which also restores the dividend on /0.
    assign quo_fix = div0_q ? DIV0_QUO : (neg_quo_q ? (~core_quo + 32'd1) : core_quo);
    assign rem_fix = neg_rem_q ? (~core_rem + 32'd1) : core_rem;

    assign bus.grant  = grant_q;
    assign bus.done   = (state_q == ST_DONE) ? grant_q : '0;
    assign bus.result = (state_q == ST_DONE) ? (want_rem_q ? rem_fix : quo_fix) : '0;
    assign bus.busy   = (state_q != ST_IDLE);
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: directed corner cases and randomized divides scored
// against a plain-arithmetic reference, plus round-robin, abort and reset cases.
module tb_div_arbiter;
    import div_arbiter_pkg::*;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    state_e      dbg_state;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] exp_q[$];

    div_arbiter_if #(.NUM_REQ(N)) bus ();

    div_arbiter #(.NUM_REQ(N)) dut (
        .wb_clk_i  (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking and reference ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn, input logic wr);
        longint sa, sb, q, r;
        if (b == 32'd0) return wr ? a : 32'hFFFF_FFFF;
        if (!sgn) return wr ? (a % b) : (a / b);
        sa = $signed(a);
        sb = $signed(b);
        q  = sa / sb;
        r  = sa % sb;
        return wr ? r[31:0] : q[31:0];
    endfunction

    // ---------------- drivers ----------------
    task automatic set_lane(input int lane, input logic [31:0] a, input logic [31:0] b,
                            input logic sgn, input logic wr);
        bus.dividend[32*lane +: 32] = a;
        bus.divisor[32*lane +: 32]  = b;
        bus.is_signed[lane]         = sgn;
        bus.want_rem[lane]          = wr;
    endtask

    task automatic wait_grant(output int k);
        k = -1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (bus.grant != '0) begin
                k = cyc;
                break;
            end
        end
    endtask

    task automatic wait_done(input logic [N-1:0] oh, output int k_done, output int hold_bad);
        k_done   = -1;
        hold_bad = 0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (bus.grant !== oh) hold_bad++;
            if (bus.done != '0) begin
                k_done = cyc;
                break;
            end
        end
    endtask

    // Latency counts rising edges from the grant edge to the edge that captures done.
    task automatic run_op(input string tag, input int lane, input logic [31:0] a,
                          input logic [31:0] b, input logic sgn, input logic wr);
        logic [N-1:0] oh;
        int k, k_done, hold_bad;
        oh       = '0;
        oh[lane] = 1'b1;
        set_lane(lane, a, b, sgn, wr);
        exp_q.push_back(ref_div(a, b, sgn, wr));
        bus.req[lane] = 1'b1;
        wait_grant(k);
        check_eq({tag, "_grant"}, 32'(bus.grant), 32'(oh));
        set_lane(lane, $urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        wait_done(oh, k_done, hold_bad);
        check_eq({tag, "_done"}, 32'(bus.done), 32'(oh));
        check_eq({tag, "_lat"}, 32'(k_done - k + 1), 32'd33);
        check_eq({tag, "_res"}, bus.result, exp_q.pop_front());
        check_eq({tag, "_hold"}, 32'(hold_bad), 32'd0);
        bus.req[lane] = 1'b0;
        @(negedge clk);
        check_eq({tag, "_idle"}, {30'd0, bus.busy, |bus.done}, 32'd0);
    endtask

    // All lanes request continuously from reset; the pointer model predicts the order.
    task automatic rr_test();
        logic [31:0] la[N], lb[N];
        logic        ls[N], lw[N];
        int rr, got_lane, exp_lane, prev_cyc, n_done;
        rst = 1'b1;
        for (int l = 0; l < N; l++) begin
            la[l] = $urandom();
            lb[l] = 32'($urandom_range(1, 1000));
            ls[l] = 1'($urandom_range(0, 1));
            lw[l] = 1'($urandom_range(0, 1));
            set_lane(l, la[l], lb[l], ls[l], lw[l]);
        end
        bus.req = '1;
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        rr       = 0;
        n_done   = 0;
        prev_cyc = 0;
        for (int t = 0; t < 200 && n_done < 5; t++) begin
            @(negedge clk);
            if (bus.done != '0) begin
                exp_lane = rr;
                rr       = (rr + 1) % N;
                got_lane = -1;
                for (int l = 0; l < N; l++) if (bus.done[l]) got_lane = l;
                check_eq($sformatf("rr_lane%0d", n_done), 32'(got_lane), 32'(exp_lane));
                check_eq($sformatf("rr_res%0d", n_done), bus.result,
                         ref_div(la[exp_lane], lb[exp_lane], ls[exp_lane], lw[exp_lane]));
                if (n_done > 0) check_eq($sformatf("rr_gap%0d", n_done), 32'(cyc - prev_cyc), 32'd34);
                prev_cyc = cyc;
                n_done++;
                if (n_done == 5) bus.req = '0;
            end
        end
        check_eq("rr_count", 32'(n_done), 32'd5);
        @(negedge clk);
    endtask

    task automatic abort_test();
        int k, k_done, hold_bad, done_seen;
        rst     = 1'b1;
        bus.req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        set_lane(3, $urandom(), 32'($urandom_range(1, 99)), 1'b0, 1'b0);
        set_lane(0, 32'd200, 32'd10, 1'b0, 1'b0);
        bus.req[3] = 1'b1;
        wait_grant(k);
        check_eq("abort_grant3", 32'(bus.grant), 32'h8);
        bus.req[0] = 1'b1;
        done_seen  = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (bus.done != '0) done_seen++;
        end
        bus.req[3] = 1'b0;
        @(negedge clk);
        check_eq("abort_busy", 32'(bus.busy), 32'd0);
        check_eq("abort_nodone", 32'(done_seen) + 32'(bus.done), 32'd0);
        check_eq("abort_grant_clr", 32'(bus.grant), 32'd0);
        @(negedge clk);
        check_eq("abort_grant0", 32'(bus.grant), 32'h1);
        k = cyc;
        wait_done(4'b0001, k_done, hold_bad);
        check_eq("abort_next_lat", 32'(k_done - k + 1), 32'd33);
        check_eq("abort_next_res", bus.result, 32'd20);
        bus.req[0] = 1'b0;
        @(negedge clk);
    endtask

    task automatic reset_test();
        int k, done_seen;
        set_lane(2, $urandom(), 32'($urandom_range(1, 500)), 1'($urandom_range(0, 1)), 1'b0);
        bus.req[2] = 1'b1;
        wait_grant(k);
        check_eq("rst_run_grant", 32'(bus.grant), 32'h4);
        done_seen = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (bus.done != '0) done_seen++;
        end
        rst        = 1'b1;
        bus.req[2] = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_grant", 32'(bus.grant), 32'd0);
        check_eq("rst_mid_done", 32'(bus.done) + 32'(done_seen), 32'd0);
        check_eq("rst_mid_result", bus.result, 32'd0);
        check_eq("rst_mid_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_after_idle", 32'(bus.busy), 32'd0);
        run_op("post_rst", 2, $urandom(), 32'($urandom_range(1, 500)), 1'b1, 1'b1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] ra, rb;
        int          mode;
        rst           = 1'b1;
        bus.req       = '0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.is_signed = '0;
        bus.want_rem  = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_grant", 32'(bus.grant), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_result", bus.result, 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_no_req", 32'(bus.busy), 32'd0);

        run_op("u100_7_q",   0, 32'd100,       32'd7,         1'b0, 1'b0);
        run_op("u100_7_r",   0, 32'd100,       32'd7,         1'b0, 1'b1);
        run_op("s_m7_2_q",   2, 32'hFFFF_FFF9, 32'd2,         1'b1, 1'b0);
        run_op("s_m7_2_r",   2, 32'hFFFF_FFF9, 32'd2,         1'b1, 1'b1);
        run_op("s_min_m1_q", 2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op("s_min_m1_r", 2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
        run_op("dz_q",       1, 32'h0000_1234, 32'd0,         1'b0, 1'b0);
        run_op("dz_r",       1, 32'h0000_1234, 32'd0,         1'b0, 1'b1);
        run_op("dz_s_q",     3, 32'hFFFF_FF00, 32'd0,         1'b1, 1'b0);
        run_op("dz_s_r",     3, 32'hFFFF_FF00, 32'd0,         1'b1, 1'b1);
        run_op("u_max_1",    3, 32'hFFFF_FFFF, 32'd1,         1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            ra   = $urandom();
            mode = $urandom_range(0, 3);
            case (mode)
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = $urandom();
                default: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 14));
            endcase
            run_op($sformatf("rand%0d", i), $urandom_range(0, N - 1), ra, rb,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        rr_test();
        abort_test();
        reset_test();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
